// File: rtl/vdata_obi_responder.sv
// OBI data-port responder backed by a word RAM.
// Programmable grant stall and fixed response latency, in-order responses.
module vdata_obi_responder #(
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_OUTSTANDING = 2,
  parameter int GNT_STALL       = 0,
  parameter int RSP_LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        busy_o
);

  localparam int D  = MAX_OUTSTANDING;
  localparam int CW = $clog2(D + 1);
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int LW = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
  localparam int SW = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;
  localparam int WORDS = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [31:0]   rdata;
    logic          err;
    logic [LW-1:0] cd;
  } rsp_t;

  state_e          state_q, state_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rsp_t            ent_q [D];
  rsp_t            ent_d [D];
  logic [31:0]     mem [WORDS];

  logic            stall_ok;
  logic            accept;
  logic            retire;
  logic            in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]     rd_word;
  logic [IW-1:0]   wr_idx;

  if (GNT_STALL == 0) begin : g_nostall
    assign stall_ok = 1'b1;
  end else begin : g_stall
    assign stall_ok = (stall_q >= SW'(GNT_STALL));
  end

  // Fullness uses the registered count only, so a retiring slot
  // is not reusable in the same cycle.
  assign data_gnt_o = data_req_i && !rst_i && stall_ok
                      && (cnt_q < CW'(D));
  assign accept   = data_req_i && data_gnt_o;
  assign retire   = (cnt_q != '0) && (ent_q[0].cd == '0);

  assign data_rvalid_o = retire;
  assign data_rdata_o  = retire ? ent_q[0].rdata : '0;
  assign data_err_o    = retire ? ent_q[0].err : 1'b0;
  assign busy_o        = (cnt_q != '0);

  assign idx      = data_addr_i[ADDR_WIDTH+1:2];
  assign in_range = ((data_addr_i >> (ADDR_WIDTH + 2)) == 32'd0);
  assign rd_word  = (in_range && !data_we_i) ? mem[idx] : '0;
  assign wr_idx   = IW'(cnt_q - CW'(retire));
  assign cnt_d    = cnt_q + CW'(accept) - CW'(retire);

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    unique case (state_q)
      S_IDLE: begin
        stall_d = '0;
        if (data_req_i && !accept) begin
          state_d = S_WAIT;
          if (!stall_ok) stall_d = stall_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (accept || !data_req_i) begin
          state_d = S_IDLE;
          stall_d = '0;
        end else if (!stall_ok) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        stall_d = '0;
      end
    endcase
  end

  always_comb begin
    ent_d = ent_q;
    if (retire) begin
      for (int i = 0; i < D - 1; i++) ent_d[i] = ent_q[i+1];
      ent_d[D-1] = '0;
    end
    for (int i = 0; i < D; i++) begin
      if (ent_d[i].cd != '0) ent_d[i].cd = ent_d[i].cd - 1'b1;
    end
    if (accept) begin
      ent_d[wr_idx] = '{rdata: rd_word,
                        err:   !in_range,
                        cd:    LW'(RSP_LATENCY - 1)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stall_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < D; i++) ent_q[i] <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      ent_q   <= ent_d;
    end
  end

  // RAM has no reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vdata_obi_responder.sv
// Bench for vdata_obi_responder: four differently configured instances,
// directed transfers with a per-instance response scoreboard.
module tb_vdata_obi_responder;

  localparam int LAT  [4] = '{1, 4, 1, 3};
  localparam int MAXO [4] = '{2, 2, 1, 2};

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst    [4];
  logic        req    [4];
  logic        gnt    [4];
  logic [31:0] addr   [4];
  logic        we     [4];
  logic [3:0]  be     [4];
  logic [31:0] wdata  [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];
  logic        busy   [4];

  exp_t sb [4][$];
  int   out_m [4];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vdata_obi_responder u0 (
    .clk_i(clk), .rst_i(rst[0]), .data_req_i(req[0]),
    .data_gnt_o(gnt[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_wdata_i(wdata[0]),
    .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
    .data_err_o(err[0]), .busy_o(busy[0]));

  vdata_obi_responder #(
    .MAX_OUTSTANDING(2), .GNT_STALL(3), .RSP_LATENCY(4)
  ) u1 (
    .clk_i(clk), .rst_i(rst[1]), .data_req_i(req[1]),
    .data_gnt_o(gnt[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_wdata_i(wdata[1]),
    .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
    .data_err_o(err[1]), .busy_o(busy[1]));

  vdata_obi_responder #(
    .MAX_OUTSTANDING(1), .RSP_LATENCY(1)
  ) u2 (
    .clk_i(clk), .rst_i(rst[2]), .data_req_i(req[2]),
    .data_gnt_o(gnt[2]), .data_addr_i(addr[2]), .data_we_i(we[2]),
    .data_be_i(be[2]), .data_wdata_i(wdata[2]),
    .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]),
    .data_err_o(err[2]), .busy_o(busy[2]));

  vdata_obi_responder #(
    .MAX_OUTSTANDING(2), .RSP_LATENCY(3)
  ) u3 (
    .clk_i(clk), .rst_i(rst[3]), .data_req_i(req[3]),
    .data_gnt_o(gnt[3]), .data_addr_i(addr[3]), .data_we_i(we[3]),
    .data_be_i(be[3]), .data_wdata_i(wdata[3]),
    .data_rvalid_o(rvalid[3]), .data_rdata_o(rdata[3]),
    .data_err_o(err[3]), .busy_o(busy[3]));

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  // Returns at the negedge where gnt is seen; acceptance is the next posedge.
  task automatic xfer(input int k, input logic [31:0] a, input logic wv,
                      input logic [3:0] bv, input logic [31:0] dv,
                      input logic [31:0] ed, input logic ee,
                      output int waited);
    @(posedge clk);
    #1;
    req[k] = 1'b1;
    addr[k] = a;
    we[k] = wv;
    be[k] = bv;
    wdata[k] = dv;
    waited = 0;
    @(negedge clk);
    while (!gnt[k] && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (gnt[k]) begin
      sb[k].push_back('{ed, ee, cyc + LAT[k]});
    end else begin
      chk($sformatf("u%0d_gnt_timeout", k), 64'(gnt[k]), 64'd1);
      req[k] = 1'b0;
    end
  endtask

  task automatic idle(input int k);
    @(posedge clk);
    #1;
    req[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst[k]) begin
        chk($sformatf("u%0d_rst_outs", k),
            64'({gnt[k], rvalid[k], busy[k], err[k], rdata[k]}), 64'd0);
        out_m[k] = 0;
        sb[k].delete();
      end else begin
        if (gnt[k])
          chk($sformatf("u%0d_gnt_when_full", k),
              64'(out_m[k] < MAXO[k]), 64'd1);
        chk($sformatf("u%0d_busy", k), 64'(busy[k]),
            64'(out_m[k] != 0));
        if (rvalid[k]) begin
          chk($sformatf("u%0d_rv_unexpected", k), 64'(rvalid[k]),
              64'(sb[k].size() != 0));
          if (sb[k].size() != 0) begin
            exp_t e;
            e = sb[k].pop_front();
            chk($sformatf("u%0d_rdata", k), 64'(rdata[k]), 64'(e.d));
            chk($sformatf("u%0d_err", k), 64'(err[k]), 64'(e.e));
            chk($sformatf("u%0d_rv_cycle", k), 64'(cyc), 64'(e.c));
          end
        end else begin
          chk($sformatf("u%0d_idle_zero", k),
              64'({err[k], rdata[k]}), 64'd0);
        end
        out_m[k] += int'(req[k] && gnt[k]) - int'(rvalid[k]);
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      req[k] = 1'b0;
      addr[k] = '0;
      we[k] = 1'b0;
      be[k] = '0;
      wdata[k] = '0;
      out_m[k] = 0;
    end
    req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req[0] = 1'b0;
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;

    // default config: full write then read, same-cycle grants
    xfer(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, w);
    chk("u0_wr_gnt_wait", 64'(w), 64'd0);
    xfer(0, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, w);
    chk("u0_rd_gnt_wait", 64'(w), 64'd0);
    // partial and empty byte enables
    xfer(0, 32'h10, 1'b1, 4'h2, 32'h0000AA00, 32'h0, 1'b0, w);
    xfer(0, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0, w);
    xfer(0, 32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, w);
    xfer(0, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0, w);
    // out of range: aliasing write dropped, read errors
    xfer(0, 32'h0001_0010, 1'b1, 4'hF, 32'h11111111, 32'h0, 1'b1, w);
    xfer(0, 32'h0001_0000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, w);
    xfer(0, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0, w);
    // top word, low address bits ignored
    xfer(0, 32'h3FFC, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, w);
    xfer(0, 32'h3FFF, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, w);
    xfer(0, 32'h4000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, w);
    idle(0);

    // stalled grant, latency 4, req held across transfers
    for (int i = 0; i < 4; i++) begin
      xfer(1, 32'(i * 4), 1'b1, 4'hF, 32'hA0A0_0000 + 32'(i),
           32'h0, 1'b0, w);
      chk($sformatf("u1_wr%0d_stall", i), 64'(w), 64'd3);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1, 32'(i * 4), 1'b0, 4'h0, 32'h0,
           32'hA0A0_0000 + 32'(i), 1'b0, w);
      chk($sformatf("u1_rd%0d_stall", i), 64'(w), 64'd3);
    end
    idle(1);

    // single outstanding: grants on alternate cycles
    xfer(2, 32'h40, 1'b1, 4'hF, 32'h55AA55AA, 32'h0, 1'b0, w);
    for (int i = 0; i < 4; i++) begin
      xfer(2, 32'h40, 1'b0, 4'h0, 32'h0, 32'h55AA55AA, 1'b0, w);
      chk($sformatf("u2_rd%0d_alt", i), 64'(w), 64'd1);
    end
    idle(2);

    // reset with two reads in flight
    xfer(3, 32'h20, 1'b1, 4'hF, 32'h12345678, 32'h0, 1'b0, w);
    xfer(3, 32'h24, 1'b1, 4'hF, 32'h9ABCDEF0, 32'h0, 1'b0, w);
    idle(3);
    repeat (5) @(posedge clk);
    xfer(3, 32'h20, 1'b0, 4'h0, 32'h0, 32'h12345678, 1'b0, w);
    xfer(3, 32'h24, 1'b0, 4'h0, 32'h0, 32'h9ABCDEF0, 1'b0, w);
    @(posedge clk);
    #1;
    req[3] = 1'b0;
    rst[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[3] = 1'b0;
    @(negedge clk);
    chk("u3_busy_after_rst", 64'(busy[3]), 64'd0);
    repeat (8) @(posedge clk);
    xfer(3, 32'h20, 1'b0, 4'h0, 32'h0, 32'h12345678, 1'b0, w);
    xfer(3, 32'h24, 1'b0, 4'h0, 32'h0, 32'h9ABCDEF0, 1'b0, w);
    idle(3);

    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("u%0d_sb_drained", k), 64'(sb[k].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
